// File: rtl/fp_mul_pkg.sv
// Shared single-precision types and constants for the multiplier scheduler.
package fp_mul_pkg;

    localparam int E    = 8;
    localparam int M    = 23;
    localparam int BITS = 1 + E + M;
    localparam int BIAS = 2**(E-1) - 1;

    typedef struct packed {
        logic         sign;
        logic [E-1:0] exp;
        logic [M-1:0] man;
    } fp_t;

    typedef struct packed {
        logic zero;
        logic underflow;
        logic overflow;
        logic nan;
    } fp_flags_t;

    localparam fp_t QNAN    = '{sign: 1'b0, exp: {E{1'b1}}, man: {1'b1, {(M-1){1'b0}}}};
    localparam fp_t POS_INF = '{sign: 1'b0, exp: {E{1'b1}}, man: '0};

endpackage

// File: rtl/fp_mul_core.sv
// Combinational single-precision multiply: truncating, no rounding, flags for
// zero / underflow / overflow / NaN with priority nan > zero > overflow > underflow.
module fp_mul_core
    import fp_mul_pkg::*;
(
    input  fp_t       x,
    input  fp_t       y,
    output fp_t       result,
    output fp_flags_t flags
);

    localparam logic signed [E+1:0] EXP_TOP  = (E+2)'(2**E - 1);
    localparam logic signed [E+1:0] EXP_ZERO = '0;

    logic                  sign;
    logic [2*M+1:0]        prod;
    logic                  norm;
    logic [M-1:0]          man_n;
    logic signed [E+1:0]   exp_s;
    logic                  any_nan;
    logic                  any_zero;
    logic                  unused_low;

    always_comb begin
        sign  = x.sign ^ y.sign;
        prod  = (2*M+2)'({1'b1, x.man}) * (2*M+2)'({1'b1, y.man});
        norm  = prod[2*M+1];
        man_n = norm ? prod[2*M -: M] : prod[2*M-1 -: M];
        // Two guard bits so the biased sum can be tested for both <= 0 and >= all-ones.
        exp_s = signed'({2'b00, x.exp} + {2'b00, y.exp}
                        + {{(E+1){1'b0}}, norm} - (E+2)'(BIAS));
    end

    assign unused_low = ^prod[M-1:0];

    always_comb begin
        any_nan  = ((&x.exp) && (|x.man)) || ((&y.exp) && (|y.man));
        any_zero = ((~|x.exp) && (~|x.man)) || ((~|y.exp) && (~|y.man));
        flags    = '0;
        result   = '{sign: sign, exp: exp_s[E-1:0], man: man_n};
        if (any_nan) begin
            result    = QNAN;
            flags.nan = 1'b1;
        end else if (any_zero) begin
            result     = '{sign: sign, exp: '0, man: '0};
            flags.zero = 1'b1;
        end else if (exp_s >= EXP_TOP) begin
            result         = POS_INF;
            result.sign    = sign;
            flags.overflow = 1'b1;
        end else if (exp_s <= EXP_ZERO) begin
            result          = '{sign: sign, exp: '0, man: '0};
            flags.underflow = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one FP multiplier among NREQ requesters through
// a two-register pipeline. Optional counters under macro FPMUL_SCHED_STATS_EN.
module fp_mul_sched
    import fp_mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BITS-1:0] req_x,
    input  logic [NREQ*BITS-1:0] req_y,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [BITS-1:0]      resp_result,
    output logic                 resp_zero,
    output logic                 resp_underflow,
    output logic                 resp_overflow,
    output logic                 resp_nan,
`ifdef FPMUL_SCHED_STATS_EN
    output logic [31:0]          stat_ops,
    output logic [31:0]          stat_stall,
`endif
    output logic                 busy
);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_id;
    logic [IDW:0]   scan_idx;
    logic           grant_found;
    logic           accept;
    logic           stall_b;
    logic           adv_a;
    logic           adv_b;

    fp_t            sel_x;
    fp_t            sel_y;
    fp_t            x_a;
    fp_t            y_a;
    logic [IDW-1:0] id_a;
    logic           vld_a;

    fp_t            res_core;
    fp_flags_t      flags_core;
    fp_t            res_b;
    fp_flags_t      flags_b;
    logic [IDW-1:0] id_b;
    logic           vld_b;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            end
            if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_x = req_x[i*BITS +: BITS];
                sel_y = req_y[i*BITS +: BITS];
            end
        end
    end

    assign stall_b = vld_b & ~resp_ready;
    assign adv_b   = ~stall_b;
    assign adv_a   = ~vld_a | adv_b;
    assign accept  = grant_found & adv_a & ~reset;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (grant_id == IDW'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Stage A: operand register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_a <= 1'b0;
            x_a   <= '0;
            y_a   <= '0;
            id_a  <= '0;
        end else if (adv_a) begin
            vld_a <= accept;
            if (accept) begin
                x_a  <= sel_x;
                y_a  <= sel_y;
                id_a <= grant_id;
            end
        end
    end

    fp_mul_core u_core (
        .x      (x_a),
        .y      (y_a),
        .result (res_core),
        .flags  (flags_core)
    );

    // Stage B: result register, which directly drives the response channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_b   <= 1'b0;
            res_b   <= '0;
            flags_b <= '0;
            id_b    <= '0;
        end else if (adv_b) begin
            vld_b <= vld_a;
            if (vld_a) begin
                res_b   <= res_core;
                flags_b <= flags_core;
                id_b    <= id_a;
            end
        end
    end

    assign resp_valid     = vld_b;
    assign resp_id        = id_b;
    assign resp_result    = res_b;
    assign resp_zero      = flags_b.zero;
    assign resp_underflow = flags_b.underflow;
    assign resp_overflow  = flags_b.overflow;
    assign resp_nan       = flags_b.nan;
    assign busy           = vld_a | vld_b;

`ifdef FPMUL_SCHED_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (vld_b && resp_ready) begin
                stat_ops <= stat_ops + 32'd1;
            end
            if (stall_b) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`else
    // Statistics counters are absent from this build.
`endif

endmodule

// File: tb/tb_fp_mul_sched.sv
// Scoreboard bench for fp_mul_sched: directed cases plus randomized traffic,
// checked against an arithmetic reference model and a round-robin/occupancy model.
module tb_fp_mul_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int BITS = 32;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
    } op_t;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        zero;
        logic        unf;
        logic        ovf;
        logic        nan;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*BITS-1:0] req_x;
    logic [NREQ*BITS-1:0] req_y;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [BITS-1:0]      resp_result;
    logic                 resp_zero;
    logic                 resp_underflow;
    logic                 resp_overflow;
    logic                 resp_nan;
    logic                 busy;

    fp_mul_sched #(.NREQ(NREQ)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_x          (req_x),
        .req_y          (req_y),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_result    (resp_result),
        .resp_zero      (resp_zero),
        .resp_underflow (resp_underflow),
        .resp_overflow  (resp_overflow),
        .resp_nan       (resp_nan),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    op_t             opq [NREQ][$];
    exp_t            sb[$];
    int              acc_order[$];
    int              acc_cyc[$];
    int              n_checks = 0;
    int              n_bad = 0;
    int              cyc = 0;
    int              occ = 0;
    int              model_ptr = 0;
    int              accept_count = 0;
    int              g;
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] acc_last = '0;
    logic            take;
    logic            held_prev = 1'b0;
    logic [31:0]     held_res;
    logic [31:0]     held_tag;
    exp_t            e_pop;
    exp_t            e_push;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, wanted %h", name, act, want);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [31:0] x, input logic [31:0] y);
        op_t o;
        o.x = x;
        o.y = y;
        opq[id].push_back(o);
    endtask

    function automatic bit allEmpty();
        for (int i = 0; i < NREQ; i++) begin
            if (opq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference product from the IEEE-style field rules using plain integer maths.
    function automatic exp_t ref_mul(input int id, input logic [31:0] a, input logic [31:0] b);
        exp_t            r;
        logic            s;
        int              e;
        longint unsigned ma;
        longint unsigned mb;
        longint unsigned p;
        logic [63:0]     pv;
        logic            is_nan;
        logic            is_zero;
        s       = a[31] ^ b[31];
        is_nan  = (a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0);
        is_zero = (a[30:0] == 0) || (b[30:0] == 0);
        ma      = {41'd0, 1'b1, a[22:0]};
        mb      = {41'd0, 1'b1, b[22:0]};
        p       = ma * mb;
        e       = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p >= (64'd1 << 47)) begin
            p = p >> 24;
            e = e + 1;
        end else begin
            p = p >> 23;
        end
        pv     = p;
        r.id   = id;
        r.zero = 1'b0;
        r.unf  = 1'b0;
        r.ovf  = 1'b0;
        r.nan  = 1'b0;
        if (is_nan) begin
            r.res = 32'h7FC00000;
            r.nan = 1'b1;
        end else if (is_zero) begin
            r.res  = {s, 31'd0};
            r.zero = 1'b1;
        end else if (e >= 255) begin
            r.res = {s, 8'hFF, 23'd0};
            r.ovf = 1'b1;
        end else if (e <= 0) begin
            r.res = {s, 31'd0};
            r.unf = 1'b1;
        end else begin
            r.res = {s, 8'(e), pv[22:0]};
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [7:0]  e;
        logic [22:0] m;
        int          pick;
        pick = $urandom_range(0, 7);
        case (pick)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'h01;
            3:       e = 8'hFE;
            4:       e = 8'h7F;
            default: e = 8'($urandom);
        endcase
        m = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    // Requesters: present the head of each queue, retire it once accepted.
    initial begin
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc_last[i] && opq[i].size() > 0) void'(opq[i].pop_front());
                if (opq[i].size() > 0) begin
                    req_valid[i]            = 1'b1;
                    req_x[i*BITS +: BITS]   = opq[i][0].x;
                    req_y[i*BITS +: BITS]   = opq[i][0].y;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: predicts grants, pushes expected results on accept, pops on response.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                sb.delete();
                acc_order.delete();
                acc_cyc.delete();
                occ       = 0;
                model_ptr = 0;
                acc_last  = '0;
                held_prev = 1'b0;
            end else begin
                g = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(model_ptr + k) % NREQ]) g = (model_ptr + k) % NREQ;
                end
                exp_ready = '0;
                if (g >= 0 && (occ < 2 || resp_ready)) exp_ready[g] = 1'b1;
                checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));

                if (held_prev) begin
                    checkOutput("hold_result", resp_result, held_res);
                    checkOutput("hold_tag", 32'({resp_valid, resp_id, resp_zero, resp_underflow,
                                                 resp_overflow, resp_nan}), held_tag);
                end
                held_prev = resp_valid && !resp_ready;
                held_res  = resp_result;
                held_tag  = 32'({1'b1, resp_id, resp_zero, resp_underflow, resp_overflow, resp_nan});

                take = resp_valid && resp_ready;
                if (take) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_bad++;
                        $display("[TB] FAIL unexpected_resp: got id %0d result %h, wanted no response",
                                 resp_id, resp_result);
                    end else begin
                        e_pop = sb.pop_front();
                        checkOutput("resp_id", 32'(resp_id), 32'(e_pop.id));
                        checkOutput("resp_result", resp_result, e_pop.res);
                        checkOutput("resp_flags",
                                    32'({resp_zero, resp_underflow, resp_overflow, resp_nan}),
                                    32'({e_pop.zero, e_pop.unf, e_pop.ovf, e_pop.nan}));
                    end
                    occ--;
                end

                if (exp_ready != '0 && opq[g].size() > 0) begin
                    e_push = ref_mul(g, opq[g][0].x, opq[g][0].y);
                    sb.push_back(e_push);
                    model_ptr = (g + 1) % NREQ;
                    occ++;
                end

                acc_last = req_valid & req_ready;
                for (int i = 0; i < NREQ; i++) begin
                    if (acc_last[i]) begin
                        acc_order.push_back(i);
                        acc_cyc.push_back(cyc);
                        accept_count++;
                    end
                end
            end
        end
    end

    task automatic waitDrain(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (allEmpty() && sb.size() == 0 && !busy) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_bad++;
            $display("[TB] FAIL %s: got pending sb=%0d busy=%0b after budget, wanted drained",
                     name, sb.size(), busy);
        end
    endtask

    task automatic applyReset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) opq[i].delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no finish, wanted completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int base;
        reset      = 1'b1;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_resp_result", resp_result, 32'd0);
        checkOutput("rst_resp_tag", 32'({resp_id, resp_zero, resp_underflow, resp_overflow, resp_nan}), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Single op: valid shown after edge k-1, accepted at edge k, response sampled at edge k+2.
        @(posedge clk);
        #2;
        applyStimulus(0, 32'h3FC00000, 32'h40000000);
        @(posedge clk);
        @(negedge clk);
        checkOutput("lat_before_accept", 32'(resp_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_stage_a_valid", 32'(resp_valid), 32'd0);
        checkOutput("lat_stage_a_busy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("lat_resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("lat_resp_result", resp_result, 32'h40400000);
        waitDrain("drain_single");

        applyStimulus(2, 32'hC0000000, 32'h3F000000);
        waitDrain("drain_sign");

        applyStimulus(1, 32'h00000000, 32'h40400000);
        applyStimulus(1, 32'h7F000000, 32'h7F000000);
        applyStimulus(1, 32'h7FC00001, 32'h3F800000);
        applyStimulus(1, 32'h00800000, 32'h00800000);
        waitDrain("drain_flags");

        // Round robin from a fresh pointer with all four requesters busy.
        applyReset();
        @(posedge clk);
        #2;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) applyStimulus(i, rand_operand(), rand_operand());
        end
        waitDrain("drain_rr");
        checkOutput("rr_count", 32'(acc_order.size()), 32'd8);
        if (acc_order.size() == 8) begin
            for (int k = 0; k < 8; k++) checkOutput("rr_order", 32'(acc_order[k]), 32'(k % NREQ));
            checkOutput("rr_throughput", 32'(acc_cyc[7] - acc_cyc[0]), 32'd7);
        end

        // Backpressure: two ops absorbed, then every requester is held off.
        @(posedge clk);
        #2;
        resp_ready = 1'b0;
        base = accept_count;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) applyStimulus(i, rand_operand(), rand_operand());
        end
        repeat (6) @(negedge clk);
        checkOutput("bp_accepts", 32'(accept_count - base), 32'd2);
        checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
        checkOutput("bp_resp_valid", 32'(resp_valid), 32'd1);
        @(posedge clk);
        #2;
        resp_ready = 1'b1;
        waitDrain("drain_bp");

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #2;
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (opq[i].size() < 2 && $urandom_range(0, 2) == 0)
                    applyStimulus(i, rand_operand(), rand_operand());
            end
        end
        @(posedge clk);
        #2;
        resp_ready = 1'b1;
        waitDrain("drain_random");

        // Reset while both stages hold work.
        @(posedge clk);
        #2;
        resp_ready = 1'b0;
        applyStimulus(2, 32'h3F800000, 32'h40000000);
        applyStimulus(3, 32'h40000000, 32'h40000000);
        applyStimulus(2, 32'h40400000, 32'h40000000);
        repeat (5) @(negedge clk);
        checkOutput("pre_reset_valid", 32'(resp_valid), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_valid", 32'(resp_valid), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        checkOutput("mid_reset_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < NREQ; i++) opq[i].delete();
        repeat (2) @(posedge clk);
        #2;
        reset      = 1'b0;
        resp_ready = 1'b1;
        applyStimulus(3, 32'h3F800000, 32'h3F800000);
        applyStimulus(1, 32'h40000000, 32'h3F800000);
        waitDrain("drain_after_reset");
        checkOutput("post_reset_count", 32'(acc_order.size()), 32'd2);
        if (acc_order.size() >= 2) begin
            checkOutput("post_reset_first", 32'(acc_order[0]), 32'd1);
            checkOutput("post_reset_second", 32'(acc_order[1]), 32'd3);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
